// File: rtl/qubit_measure_unit.sv
// Single-qubit projective measurement: P(|0>) = re^2 + im^2, sampled against rand_in[15:0].
// Optional outcome counters are compiled in when MEAS_STATS_EN is defined.
module qubit_measure_unit #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] amp0_re,
   input  logic [WIDTH-1:0] amp0_im,
   input  logic [WIDTH-1:0] rand_in,
   output logic             busy,
   output logic             done,
   output logic             outcome,
   output logic [WIDTH-1:0] prob0,
   output logic [WIDTH-1:0] post_amp0_re,
   output logic [WIDTH-1:0] post_amp0_im,
   output logic [WIDTH-1:0] post_amp1_re,
   output logic [WIDTH-1:0] post_amp1_im,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {IDLE, SQ_RE, SQ_IM, SAMPLE, DONE} state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

   state_t                   state;
   logic [WIDTH-1:0]         re_q;
   logic [WIDTH-1:0]         im_q;
   logic [2*WIDTH-1:0]       acc;
   logic [WIDTH-1:0]         mul_op;
   logic signed [2*WIDTH-1:0] op_ext;
   logic signed [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]         p_raw;
   logic                     p_ovf;
   logic [WIDTH-1:0]         p_sat;
   logic [WIDTH-1:0]         r_ext;
   logic                     out_bit;

   // One multiplier shared between the two squaring states.
   assign mul_op = (state == SQ_RE) ? re_q : im_q;
   assign op_ext = {{WIDTH{mul_op[WIDTH-1]}}, mul_op};
   assign prod   = op_ext * op_ext;

   assign p_raw   = acc[WIDTH+FRAC-1:FRAC];
   assign p_ovf   = |acc[2*WIDTH-1:WIDTH+FRAC];
   assign p_sat   = (p_ovf || (p_raw > ONE)) ? ONE : p_raw;
   assign r_ext   = {{(WIDTH-FRAC){1'b0}}, rand_in[FRAC-1:0]};
   // Strict compare: p = 1.0 always yields 0, p = 0 always yields 1.
   assign out_bit = (r_ext < p_sat) ? 1'b0 : 1'b1;

   assign state_dbg    = state;
   assign post_amp0_im = '0;
   assign post_amp1_im = '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         re_q         <= '0;
         im_q         <= '0;
         acc          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         outcome      <= 1'b0;
         prob0        <= '0;
         post_amp0_re <= '0;
         post_amp1_re <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  re_q  <= amp0_re;
                  im_q  <= amp0_im;
                  busy  <= 1'b1;
                  state <= SQ_RE;
               end
            end
            SQ_RE: begin
               acc   <= prod;
               state <= SQ_IM;
            end
            SQ_IM: begin
               acc   <= acc + prod;
               state <= SAMPLE;
            end
            SAMPLE: begin
               prob0        <= p_sat;
               outcome      <= out_bit;
               post_amp0_re <= out_bit ? '0 : ONE;
               post_amp1_re <= out_bit ? ONE : '0;
               busy         <= 1'b0;
               done         <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEAS_STATS_EN
   logic [WIDTH-FRAC-1:0] unused_rand_hi;
   assign unused_rand_hi = rand_in[WIDTH-1:FRAC];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (stats_clr) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (state == SAMPLE) begin
         if (out_bit) cnt1 <= cnt1 + 1'b1;
         else         cnt0 <= cnt0 + 1'b1;
      end
   end
`else
   logic unused_inputs;
   assign unused_inputs = ^{stats_clr, rand_in[WIDTH-1:FRAC]};
   assign cnt0 = '0;
   assign cnt1 = '0;
`endif

endmodule
